decode_stage_nw: RTL and testbench

- Registered, N-wide successor to the single-lane combinational decoder.
- Accepts a fetch bundle of DECODE_WIDTH instructions per beat and decodes each lane to an ooop_types::decode_pkt_t.
- Holds results in a two-entry (main + skid) output buffer, so rename sees registered outputs and full-throughput valid/ready without a combinational ready path.
- Sits between fetch and rename; adds flush, post-taken-lane squashing and a decoded-instruction counter.

---
 rtl/decode_stage_nw.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_decode_stage_nw.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_nw.sv
// N-wide registered decode stage: per-lane RV32I decode, taken-branch squashing, and a main+skid output buffer.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds illegal_out and makes an illegal lane squash the younger lanes.

package ooop_types;

   typedef enum logic [1:0] {
      FU_NONE = 2'd0,
      FU_ALU  = 2'd1,
      FU_BRU  = 2'd2,
      FU_LSU  = 2'd3
   } fu_type_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // ls_size: 0 = byte, 1 = half, 2 = word
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] predicted_target;
      logic        predicted_taken;
      fu_type_e    fu_type;
      alu_op_e     alu_op;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_used;
      logic        rs1_used;
      logic        rs2_used;
      logic        is_branch;
      logic        is_jump;
      logic        is_load;
      logic        is_store;
      logic [1:0]  ls_size;
      logic        unsigned_load;
   } decode_pkt_t;

endpackage

module decode_stage_nw
   import ooop_types::*;
#(
   parameter int DECODE_WIDTH = 2,
   parameter int CNT_W        = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           valid_in,
   output logic                           ready_out,
   input  logic [DECODE_WIDTH-1:0]        lane_valid_in,
   input  logic [DECODE_WIDTH*32-1:0]     pc_in,
   input  logic [DECODE_WIDTH*32-1:0]     instr_in,
   input  logic [DECODE_WIDTH-1:0]        predicted_taken_in,
   input  logic [DECODE_WIDTH*32-1:0]     predicted_target_in,
   output logic                           valid_out,
   input  logic                           ready_in,
   output logic [DECODE_WIDTH-1:0]        lane_valid_out,
   output decode_pkt_t [DECODE_WIDTH-1:0] pkt_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic [DECODE_WIDTH-1:0]        illegal_out,
`endif
   output logic [CNT_W-1:0]               decoded_count
);

   typedef struct packed {
`ifdef DECODE_ILLEGAL_TRAP_EN
      logic [DECODE_WIDTH-1:0] illegal;
`endif
      logic [DECODE_WIDTH-1:0]        lanes;
      decode_pkt_t [DECODE_WIDTH-1:0] pkts;
   } bundle_t;

   // Only the encodings this pipeline executes are legal; everything else is
   // either trapped or turned into a NOP lane.
   function automatic logic lane_illegal(input logic [31:0] instr);
      logic [2:0] f3;
      logic [6:0] f7;
      logic       bad;
      f3 = instr[14:12];
      f7 = instr[31:25];
      case (instr[6:0])
         OPC_LUI, OPC_JAL, OPC_JALR, OPC_OP_IMM: bad = 1'b0;
         OPC_OP:     bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
         OPC_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         OPC_STORE:  bad = f3[2] || (f3[1:0] == 2'b11);
         OPC_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic decode_pkt_t decode_lane(input logic [31:0] instr,
                                               input logic [31:0] pc,
                                               input logic        pt,
                                               input logic [31:0] ptgt);
      decode_pkt_t p;
      logic [31:0] immI, immS, immB, immU, immJ;
      logic [2:0]  f3;
      p    = '0;
      p.pc = pc;
      f3   = instr[14:12];
      immI = {{20{instr[31]}}, instr[31:20]};
      immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      immU = {instr[31:12], 12'b0};
      immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      if (!lane_illegal(instr)) begin
         p.predicted_taken  = pt;
         p.predicted_target = ptgt;
         p.funct3           = f3;
         p.rd               = instr[11:7];
         p.rs1              = instr[19:15];
         p.rs2              = instr[24:20];
         case (instr[6:0])
            OPC_LUI: begin
               p.fu_type = FU_ALU;
               p.alu_op  = ALU_LUI;
               p.imm     = immU;
               p.rd_used = (instr[11:7] != 5'd0);
            end
            OPC_JAL: begin
               p.fu_type = FU_BRU;
               p.is_jump = 1'b1;
               p.imm     = immJ;
               p.rd_used = (instr[11:7] != 5'd0);
            end
            OPC_JALR: begin
               p.fu_type  = FU_BRU;
               p.is_jump  = 1'b1;
               p.imm      = immI;
               p.rs1_used = 1'b1;
               p.rd_used  = (instr[11:7] != 5'd0);
            end
            OPC_OP_IMM: begin
               p.fu_type  = FU_ALU;
               p.alu_op   = alu_decode(f3, instr[30] && (f3 == 3'b101));
               p.imm      = immI;
               p.rs1_used = 1'b1;
               p.rd_used  = (instr[11:7] != 5'd0);
            end
            OPC_OP: begin
               p.fu_type  = FU_ALU;
               p.alu_op   = alu_decode(f3, instr[30] && ((f3 == 3'b000) || (f3 == 3'b101)));
               p.rs1_used = 1'b1;
               p.rs2_used = 1'b1;
               p.rd_used  = (instr[11:7] != 5'd0);
            end
            OPC_LOAD: begin
               p.fu_type       = FU_LSU;
               p.is_load       = 1'b1;
               p.imm           = immI;
               p.rs1_used      = 1'b1;
               p.rd_used       = (instr[11:7] != 5'd0);
               p.ls_size       = f3[1:0];
               p.unsigned_load = f3[2];
            end
            OPC_STORE: begin
               p.fu_type  = FU_LSU;
               p.is_store = 1'b1;
               p.imm      = immS;
               p.rs1_used = 1'b1;
               p.rs2_used = 1'b1;
               p.ls_size  = f3[1:0];
            end
            default: begin
               p.fu_type   = FU_BRU;
               p.is_branch = 1'b1;
               p.imm       = immB;
               p.rs1_used  = 1'b1;
               p.rs2_used  = 1'b1;
            end
         endcase
      end
      return p;
   endfunction

   decode_pkt_t [DECODE_WIDTH-1:0] lanePkt;
   logic [DECODE_WIDTH-1:0]        effValid;
   logic [DECODE_WIDTH-1:0]        laneIllegal;
   logic                           blocked;
   bundle_t                        newBundle;

   // A valid lane that is predicted taken (or trapped) ends the bundle: younger lanes are squashed.
   always_comb begin
      blocked     = 1'b0;
      lanePkt     = '0;
      effValid    = '0;
      laneIllegal = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         lanePkt[i]     = decode_lane(instr_in[i*32 +: 32], pc_in[i*32 +: 32],
                                      predicted_taken_in[i], predicted_target_in[i*32 +: 32]);
         laneIllegal[i] = lane_illegal(instr_in[i*32 +: 32]);
         effValid[i]    = lane_valid_in[i] && !blocked;
`ifdef DECODE_ILLEGAL_TRAP_EN
         if (lane_valid_in[i] && (predicted_taken_in[i] || laneIllegal[i]))
            blocked = 1'b1;
`else
         if (lane_valid_in[i] && predicted_taken_in[i])
            blocked = 1'b1;
`endif
      end
   end

   always_comb begin
      newBundle       = '0;
      newBundle.lanes = effValid;
      newBundle.pkts  = lanePkt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      newBundle.illegal = laneIllegal & effValid;
`endif
   end

   bundle_t          main_q, main_d, skid_q, skid_d;
   logic             mainFull_q, mainFull_d, skidFull_q, skidFull_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] deliverCnt;
   logic             enq, drained;

   always_comb begin
      deliverCnt = '0;
      for (int i = 0; i < DECODE_WIDTH; i++)
         deliverCnt = deliverCnt + CNT_W'(main_q.lanes[i]);
   end

   // Flush wins over everything; otherwise the main entry refills from skid first to keep order.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      mainFull_d = mainFull_q;
      skidFull_d = skidFull_q;
      count_d    = count_q;
      enq        = valid_in && !skidFull_q && (|effValid);
      drained    = !mainFull_q || ready_in;
      if (flush) begin
         mainFull_d = 1'b0;
         skidFull_d = 1'b0;
      end else begin
         if (mainFull_q && ready_in)
            count_d = count_q + deliverCnt;
         if (drained) begin
            if (skidFull_q) begin
               main_d     = skid_q;
               mainFull_d = 1'b1;
               skidFull_d = enq;
               if (enq)
                  skid_d = newBundle;
            end else begin
               mainFull_d = enq;
               if (enq)
                  main_d = newBundle;
            end
         end else if (enq) begin
            skid_d     = newBundle;
            skidFull_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q     <= '0;
         skid_q     <= '0;
         mainFull_q <= 1'b0;
         skidFull_q <= 1'b0;
         count_q    <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         mainFull_q <= mainFull_d;
         skidFull_q <= skidFull_d;
         count_q    <= count_d;
      end
   end

   assign ready_out      = !skidFull_q;
   assign valid_out      = mainFull_q;
   assign lane_valid_out = main_q.lanes & {DECODE_WIDTH{mainFull_q}};
   assign pkt_out        = main_q.pkts;
   assign decoded_count  = count_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign illegal_out    = main_q.illegal & {DECODE_WIDTH{mainFull_q}};
`endif

endmodule

// File: tb/tb_decode_stage_nw.sv
// Directed-vector bench for decode_stage_nw (2 lanes); illegal-lane checks follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_stage_nw;
   import ooop_types::*;

   localparam int W = 2;

   logic                clk = 1'b0;
   logic                reset, flush, valid_in, ready_in;
   logic                ready_out, valid_out;
   logic [W-1:0]        lane_valid_in, predicted_taken_in, lane_valid_out;
   logic [W*32-1:0]     pc_in, instr_in, predicted_target_in;
   decode_pkt_t [W-1:0] pkt_out;
   logic [31:0]         decoded_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic [W-1:0]        illegal_out;
`endif

   int vectors     = 0;
   int miscompares = 0;
   decode_pkt_t expPkt;

   decode_stage_nw #(.DECODE_WIDTH(W), .CNT_W(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .flush               (flush),
      .valid_in            (valid_in),
      .ready_out           (ready_out),
      .lane_valid_in       (lane_valid_in),
      .pc_in               (pc_in),
      .instr_in            (instr_in),
      .predicted_taken_in  (predicted_taken_in),
      .predicted_target_in (predicted_target_in),
      .valid_out           (valid_out),
      .ready_in            (ready_in),
      .lane_valid_out      (lane_valid_out),
      .pkt_out             (pkt_out),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .illegal_out         (illegal_out),
`endif
      .decoded_count       (decoded_count)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [1:0] lanes, input logic [1:0] pt,
                                input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc0);
      valid_in            = v;
      lane_valid_in       = lanes;
      predicted_taken_in  = pt;
      instr_in            = {i1, i0};
      pc_in               = {pc0 + 32'd4, pc0};
      predicted_target_in = {32'h0000_9004, 32'h0000_9000};
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      reset = 1'b1; flush = 1'b0; ready_in = 1'b1;
      idle();
      step(); step();
      reset = 1'b0;
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset valid_out got %b want 0", valid_out); end
      vectors++; if (lane_valid_out !== 2'b00) begin miscompares++; $display("[TB] FAIL reset lane_valid_out got %b want 00", lane_valid_out); end
      vectors++; if (pkt_out !== '0) begin miscompares++; $display("[TB] FAIL reset pkt_out got %h want 0", pkt_out); end
      vectors++; if (decoded_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset count got %0d want 0", decoded_count); end
      step();
      vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL reset ready_out got %b want 1", ready_out); end
   endtask

   task automatic test_addi;
      applyStimulus(1'b1, 2'b01, 2'b00, 32'h00500093, 32'h0, 32'h100);
      step(); idle();
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL addi valid_out got %b want 1", valid_out); end
      vectors++; if (lane_valid_out !== 2'b01) begin miscompares++; $display("[TB] FAIL addi lanes got %b want 01", lane_valid_out); end
      vectors++; if (pkt_out[0].fu_type !== FU_ALU) begin miscompares++; $display("[TB] FAIL addi fu got %h want %h", pkt_out[0].fu_type, FU_ALU); end
      vectors++; if (pkt_out[0].alu_op !== ALU_ADD) begin miscompares++; $display("[TB] FAIL addi alu_op got %h want %h", pkt_out[0].alu_op, ALU_ADD); end
      vectors++; if (pkt_out[0].imm !== 32'd5) begin miscompares++; $display("[TB] FAIL addi imm got %h want 5", pkt_out[0].imm); end
      vectors++; if ({pkt_out[0].rd_used, pkt_out[0].rs1_used, pkt_out[0].rs2_used} !== 3'b110) begin miscompares++; $display("[TB] FAIL addi used got %b want 110", {pkt_out[0].rd_used, pkt_out[0].rs1_used, pkt_out[0].rs2_used}); end
      vectors++; if (pkt_out[0].pc !== 32'h100) begin miscompares++; $display("[TB] FAIL addi pc got %h want 100", pkt_out[0].pc); end
      step();
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL addi drain valid_out got %b want 0", valid_out); end
      vectors++; if (decoded_count !== 32'd1) begin miscompares++; $display("[TB] FAIL addi count got %0d want 1", decoded_count); end
   endtask

   task automatic test_decode_mix;
      // LW x5,8(x2) | SW x2,12(x1)
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00812283, 32'h0020A623, 32'h200);
      step(); idle();
      vectors++; if (lane_valid_out !== 2'b11) begin miscompares++; $display("[TB] FAIL ldst lanes got %b want 11", lane_valid_out); end
      vectors++; if ({pkt_out[0].fu_type, pkt_out[0].is_load, pkt_out[0].ls_size, pkt_out[0].unsigned_load} !== {FU_LSU, 1'b1, 2'd2, 1'b0}) begin miscompares++; $display("[TB] FAIL lw fields got %h want %h", {pkt_out[0].fu_type, pkt_out[0].is_load, pkt_out[0].ls_size, pkt_out[0].unsigned_load}, {FU_LSU, 1'b1, 2'd2, 1'b0}); end
      vectors++; if (pkt_out[0].imm !== 32'd8) begin miscompares++; $display("[TB] FAIL lw imm got %h want 8", pkt_out[0].imm); end
      vectors++; if ({pkt_out[1].is_store, pkt_out[1].rs2_used, pkt_out[1].rd_used, pkt_out[1].ls_size} !== 5'b11010) begin miscompares++; $display("[TB] FAIL sw fields got %b want 11010", {pkt_out[1].is_store, pkt_out[1].rs2_used, pkt_out[1].rd_used, pkt_out[1].ls_size}); end
      vectors++; if (pkt_out[1].imm !== 32'd12) begin miscompares++; $display("[TB] FAIL sw imm got %h want c", pkt_out[1].imm); end
      vectors++; if (pkt_out[1].pc !== 32'h204) begin miscompares++; $display("[TB] FAIL sw pc got %h want 204", pkt_out[1].pc); end
      step();
      vectors++; if (decoded_count !== 32'd3) begin miscompares++; $display("[TB] FAIL ldst count got %0d want 3", decoded_count); end
      // SUB x3,x1,x2 | LUI x7,0x12345
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h402081B3, 32'h123453B7, 32'h300);
      step(); idle();
      vectors++; if (pkt_out[0].alu_op !== ALU_SUB) begin miscompares++; $display("[TB] FAIL sub alu_op got %h want %h", pkt_out[0].alu_op, ALU_SUB); end
      vectors++; if (pkt_out[0].rs2_used !== 1'b1) begin miscompares++; $display("[TB] FAIL sub rs2_used got %b want 1", pkt_out[0].rs2_used); end
      vectors++; if (pkt_out[1].alu_op !== ALU_LUI) begin miscompares++; $display("[TB] FAIL lui alu_op got %h want %h", pkt_out[1].alu_op, ALU_LUI); end
      vectors++; if (pkt_out[1].imm !== 32'h12345000) begin miscompares++; $display("[TB] FAIL lui imm got %h want 12345000", pkt_out[1].imm); end
      step();
      // JAL x1,+16 | LBU x6,0(x1)
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h010000EF, 32'h0000C303, 32'h340);
      step(); idle();
      vectors++; if ({pkt_out[0].fu_type, pkt_out[0].is_jump, pkt_out[0].rd_used} !== {FU_BRU, 1'b1, 1'b1}) begin miscompares++; $display("[TB] FAIL jal fields got %b want 1011", {pkt_out[0].fu_type, pkt_out[0].is_jump, pkt_out[0].rd_used}); end
      vectors++; if (pkt_out[0].imm !== 32'h10) begin miscompares++; $display("[TB] FAIL jal imm got %h want 10", pkt_out[0].imm); end
      vectors++; if ({pkt_out[1].unsigned_load, pkt_out[1].ls_size, pkt_out[1].funct3} !== {1'b1, 2'd0, 3'b100}) begin miscompares++; $display("[TB] FAIL lbu fields got %b want 100100", {pkt_out[1].unsigned_load, pkt_out[1].ls_size, pkt_out[1].funct3}); end
      step();
      // ADDI x1,x0,-1 | ADDI x0,x0,0
      applyStimulus(1'b1, 2'b11, 2'b00, 32'hFFF00093, 32'h00000013, 32'h380);
      step(); idle();
      vectors++; if (pkt_out[0].imm !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL addi-neg imm got %h want ffffffff", pkt_out[0].imm); end
      vectors++; if (pkt_out[1].rd_used !== 1'b0) begin miscompares++; $display("[TB] FAIL nop rd_used got %b want 0", pkt_out[1].rd_used); end
      step();
      vectors++; if (decoded_count !== 32'd9) begin miscompares++; $display("[TB] FAIL mix count got %0d want 9", decoded_count); end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 2'b11, 2'b00, {12'(k), 20'h00093}, {12'(k + 100), 20'h00113}, 32'h2000 + 32'(k * 8));
         step();
         vectors++; if (valid_out !== 1'b1 || pkt_out[0].pc !== 32'h2000 + 32'(k * 8)) begin miscompares++; $display("[TB] FAIL b2b[%0d] valid/pc got %b/%h want 1/%h", k, valid_out, pkt_out[0].pc, 32'h2000 + 32'(k * 8)); end
         vectors++; if (pkt_out[1].imm !== 32'(k + 100)) begin miscompares++; $display("[TB] FAIL b2b[%0d] lane1 imm got %0d want %0d", k, pkt_out[1].imm, k + 100); end
         vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b[%0d] ready_out got %b want 1", k, ready_out); end
      end
      idle();
      step();
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b drain valid_out got %b want 0", valid_out); end
      vectors++; if (decoded_count !== 32'd25) begin miscompares++; $display("[TB] FAIL b2b count got %0d want 25", decoded_count); end
   endtask

   task automatic test_backpressure;
      ready_in = 1'b0;
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h3000);
      step();
      vectors++; if (valid_out !== 1'b1 || pkt_out[0].pc !== 32'h3000 || ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL bp first v/pc/rdy got %b/%h/%b want 1/3000/1", valid_out, pkt_out[0].pc, ready_out); end
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h3100);
      step();
      vectors++; if (pkt_out[0].pc !== 32'h3000 || ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL bp skid pc/rdy got %h/%b want 3000/0", pkt_out[0].pc, ready_out); end
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h3200);
      step();
      vectors++; if (valid_out !== 1'b1 || pkt_out[0].pc !== 32'h3000 || ready_out !== 1'b0) begin miscompares++; $display("[TB] FAIL bp hold v/pc/rdy got %b/%h/%b want 1/3000/0", valid_out, pkt_out[0].pc, ready_out); end
      ready_in = 1'b1;
      step();
      vectors++; if (pkt_out[0].pc !== 32'h3100 || ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL bp second pc/rdy got %h/%b want 3100/1", pkt_out[0].pc, ready_out); end
      vectors++; if (decoded_count !== 32'd27) begin miscompares++; $display("[TB] FAIL bp count1 got %0d want 27", decoded_count); end
      step();
      idle();
      vectors++; if (valid_out !== 1'b1 || pkt_out[0].pc !== 32'h3200) begin miscompares++; $display("[TB] FAIL bp third v/pc got %b/%h want 1/3200", valid_out, pkt_out[0].pc); end
      step();
      vectors++; if (valid_out !== 1'b0 || decoded_count !== 32'd31) begin miscompares++; $display("[TB] FAIL bp end v/count got %b/%0d want 0/31", valid_out, decoded_count); end
   endtask

   task automatic test_taken_squash;
      applyStimulus(1'b1, 2'b11, 2'b01, 32'hFE209EE3, 32'h00500093, 32'h400);
      step(); idle();
      vectors++; if (lane_valid_out !== 2'b01) begin miscompares++; $display("[TB] FAIL squash lanes got %b want 01", lane_valid_out); end
      vectors++; if (pkt_out[0].is_branch !== 1'b1 || pkt_out[0].fu_type !== FU_BRU) begin miscompares++; $display("[TB] FAIL bne branch/fu got %b/%h want 1/%h", pkt_out[0].is_branch, pkt_out[0].fu_type, FU_BRU); end
      vectors++; if (pkt_out[0].imm !== 32'hFFFFFFFC) begin miscompares++; $display("[TB] FAIL bne imm got %h want fffffffc", pkt_out[0].imm); end
      vectors++; if (pkt_out[0].predicted_taken !== 1'b1 || pkt_out[0].predicted_target !== 32'h9000) begin miscompares++; $display("[TB] FAIL bne pred got %b/%h want 1/9000", pkt_out[0].predicted_taken, pkt_out[0].predicted_target); end
      step();
      vectors++; if (decoded_count !== 32'd32) begin miscompares++; $display("[TB] FAIL squash count got %0d want 32", decoded_count); end
      applyStimulus(1'b1, 2'b00, 2'b00, 32'h00500093, 32'h00500093, 32'h480);
      step(); idle();
      vectors++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL empty bundle v/rdy got %b/%b want 0/1", valid_out, ready_out); end
   endtask

   task automatic test_flush;
      ready_in = 1'b0;
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h5000);
      step();
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h5100);
      step();
      vectors++; if (ready_out !== 1'b0 || valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL flush prefill rdy/v got %b/%b want 0/1", ready_out, valid_out); end
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h5200);
      flush = 1'b1; ready_in = 1'b1;
      step();
      flush = 1'b0; idle();
      vectors++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin miscompares++; $display("[TB] FAIL flush v/rdy got %b/%b want 0/1", valid_out, ready_out); end
      vectors++; if (decoded_count !== 32'd32) begin miscompares++; $display("[TB] FAIL flush count got %0d want 32", decoded_count); end
      step();
      vectors++; if (valid_out !== 1'b0 || decoded_count !== 32'd32) begin miscompares++; $display("[TB] FAIL flush after v/count got %b/%0d want 0/32", valid_out, decoded_count); end
   endtask

   task automatic test_illegal;
      expPkt    = '0;
      expPkt.pc = 32'h600;
      applyStimulus(1'b1, 2'b11, 2'b00, 32'hFFFFFFFF, 32'h00500093, 32'h600);
      step(); idle();
      vectors++; if (pkt_out[0] !== expPkt) begin miscompares++; $display("[TB] FAIL illegal pkt0 got %h want %h", pkt_out[0], expPkt); end
`ifdef DECODE_ILLEGAL_TRAP_EN
      vectors++; if (illegal_out !== 2'b01) begin miscompares++; $display("[TB] FAIL illegal_out got %b want 01", illegal_out); end
      vectors++; if (lane_valid_out !== 2'b01) begin miscompares++; $display("[TB] FAIL illegal lanes got %b want 01", lane_valid_out); end
`else
      vectors++; if (lane_valid_out !== 2'b11) begin miscompares++; $display("[TB] FAIL nop lanes got %b want 11", lane_valid_out); end
      vectors++; if (pkt_out[1].imm !== 32'd5) begin miscompares++; $display("[TB] FAIL nop lane1 imm got %h want 5", pkt_out[1].imm); end
`endif
      step();
      // ADDI | MUL (funct7 0000001 is outside the base OP encodings)
      expPkt.pc = 32'h704;
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h02208133, 32'h700);
      step(); idle();
      vectors++; if (lane_valid_out !== 2'b11) begin miscompares++; $display("[TB] FAIL mul lanes got %b want 11", lane_valid_out); end
      vectors++; if (pkt_out[1] !== expPkt) begin miscompares++; $display("[TB] FAIL mul pkt1 got %h want %h", pkt_out[1], expPkt); end
`ifdef DECODE_ILLEGAL_TRAP_EN
      vectors++; if (illegal_out !== 2'b10) begin miscompares++; $display("[TB] FAIL mul illegal_out got %b want 10", illegal_out); end
`endif
      step();
   endtask

   task automatic test_async_reset;
      ready_in = 1'b0;
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h00500093, 32'h00500093, 32'h800);
      step(); idle();
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL pre-reset valid_out got %b want 1", valid_out); end
      #2 reset = 1'b1;
      #1;
      vectors++; if (valid_out !== 1'b0 || decoded_count !== 32'd0 || lane_valid_out !== 2'b00) begin miscompares++; $display("[TB] FAIL async reset v/count/lanes got %b/%0d/%b want 0/0/00", valid_out, decoded_count, lane_valid_out); end
      reset = 1'b0;
      step();
      vectors++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL post-reset rdy/v got %b/%b want 1/0", ready_out, valid_out); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_decode_mix();
      test_back_to_back();
      test_backpressure();
      test_taken_squash();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
